// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS32 MEM stage: EX/MEM register, data-memory handshake with timeout, store align, load extend
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_e,
    input  logic        reg_write_e,
    input  logic        mem_to_reg_e,
    input  logic        mem_read_e,
    input  logic        mem_write_e,
    input  logic [1:0]  mem_size_e,
    input  logic        mem_unsigned_e,
    input  logic [31:0] alu_out_e,
    input  logic [31:0] write_data_e,
    input  logic [4:0]  write_reg_e,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_m,
    output logic        misaligned_m,
    output logic        bus_err_m,
    output logic        reg_write_m,
    output logic        mem_to_reg_m,
    output logic [31:0] alu_out_m,
    output logic [31:0] read_data_m,
    output logic [4:0]  write_reg_m
);
    localparam int CW = ($clog2(TIMEOUT) + 1 > 5) ? $clog2(TIMEOUT) + 1 : 5;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_wait_cnt, w_wait_cnt_nxt;

    logic        r_valid, r_reg_write, r_mem_to_reg, r_mem_read, r_mem_write, r_mem_unsigned;
    logic [1:0]  r_mem_size;
    logic [31:0] r_alu_out, r_write_data;
    logic [4:0]  r_write_reg;

    logic        w_access, w_align_bad, w_misaligned, w_pending, w_timeout, w_stall;
    logic        w_is_byte, w_is_half;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= 1'b0;
            r_reg_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_size     <= 2'b00;
            r_mem_unsigned <= 1'b0;
            r_alu_out      <= 32'h0;
            r_write_data   <= 32'h0;
            r_write_reg    <= 5'h0;
        end else if (!w_stall) begin
            r_valid        <= valid_e;
            r_reg_write    <= reg_write_e;
            r_mem_to_reg   <= mem_to_reg_e;
            r_mem_read     <= mem_read_e;
            r_mem_write    <= mem_write_e;
            r_mem_size     <= mem_size_e;
            r_mem_unsigned <= mem_unsigned_e;
            r_alu_out      <= alu_out_e;
            r_write_data   <= write_data_e;
            r_write_reg    <= write_reg_e;
        end
    end

    // Size 2'b11 is treated as a word access.
    assign w_is_byte    = (r_mem_size == 2'b00);
    assign w_is_half    = (r_mem_size == 2'b01);
    assign w_access     = r_valid & (r_mem_read | r_mem_write);
    assign w_align_bad  = (w_is_half & r_alu_out[0]) | (r_mem_size[1] & (|r_alu_out[1:0]));
    assign w_misaligned = w_access & w_align_bad;
    assign w_pending    = !rst & w_access & !w_align_bad;
    assign w_stall      = w_pending & !dmem_ack & !w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pending && !dmem_ack) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = CW'(1);
                end
            end
            default: begin
                if (!w_pending || dmem_ack || w_timeout) begin
                    w_state_nxt    = S_IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        w_timeout = 1'b0;
        if (r_state == S_WAIT)
            w_timeout = w_pending & !dmem_ack & (r_wait_cnt == LAST_WAIT);
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_write_data;
        if (w_is_byte) begin
            w_be    = 4'b0001 << r_alu_out[1:0];
            w_wdata = {4{r_write_data[7:0]}};
        end else if (w_is_half) begin
            w_be    = r_alu_out[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_write_data[15:0]}};
        end
    end

    always_comb begin
        case (r_alu_out[1:0])
            2'd0:    w_lane_b = dmem_rdata[7:0];
            2'd1:    w_lane_b = dmem_rdata[15:8];
            2'd2:    w_lane_b = dmem_rdata[23:16];
            default: w_lane_b = dmem_rdata[31:24];
        endcase
        w_lane_h = r_alu_out[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (w_is_byte)
            w_load = {{24{!r_mem_unsigned & w_lane_b[7]}}, w_lane_b};
        else if (w_is_half)
            w_load = {{16{!r_mem_unsigned & w_lane_h[15]}}, w_lane_h};
        else
            w_load = dmem_rdata;
    end

    // Every output is forced low while rst is held, before the registers clear.
    assign dmem_req     = w_pending;
    assign dmem_we      = !rst & r_mem_write;
    assign dmem_addr    = rst ? 32'h0 : {r_alu_out[31:2], 2'b00};
    assign dmem_be      = rst ? 4'h0 : w_be;
    assign dmem_wdata   = rst ? 32'h0 : w_wdata;
    assign stall_m      = w_stall;
    assign misaligned_m = !rst & w_misaligned;
    assign bus_err_m    = w_timeout;
    assign reg_write_m  = !rst & r_reg_write & r_valid & !w_stall & !w_misaligned & !w_timeout;
    assign mem_to_reg_m = !rst & r_mem_to_reg;
    assign alu_out_m    = rst ? 32'h0 : r_alu_out;
    assign read_data_m  = rst ? 32'h0 : w_load;
    assign write_reg_m  = rst ? 5'h0 : r_write_reg;
endmodule
